// File: rtl/output_link_scheduler.sv
// rtl/output_link_scheduler.sv - round-robin wormhole arbiter driving one registered router output link
//
// Flit layout: bits [FLIT_W-1:FLIT_W-2] carry the label
//   2'b00 BODY, 2'b01 HEAD, 2'b10 TAIL, 2'b11 HEADTAIL; remaining bits are payload.
module output_link_scheduler #(
  parameter int N_REQ  = 5,
  parameter int PTR_W  = $clog2(N_REQ),
  parameter int FLIT_W = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_i,
  input  logic [N_REQ-1:0][FLIT_W-1:0]  req_flit_i,
  output logic [N_REQ-1:0]              grant_o,
  output logic [FLIT_W-1:0]             data_o,
  output logic                          valid_o,
  input  logic                          on_off_i,
  input  logic                          allocatable_i,
  output logic                          err_o
);

  localparam logic [1:0] LBL_BODY     = 2'b00;
  localparam logic [1:0] LBL_HEAD     = 2'b01;
  localparam logic [1:0] LBL_TAIL     = 2'b10;
  localparam logic [1:0] LBL_HEADTAIL = 2'b11;
  localparam int         SW           = PTR_W + 1;

  typedef enum logic {S_IDLE, S_LOCKED} state_t;

  state_t              r_state;
  logic [PTR_W-1:0]    r_owner;
  logic [PTR_W-1:0]    r_rr_ptr;
  logic [FLIT_W-1:0]   r_data;
  logic                r_valid;
  logic                r_err;

  state_t              w_state_nxt;
  logic [PTR_W-1:0]    w_owner_nxt;
  logic [PTR_W-1:0]    w_ptr_nxt;
  logic                w_err_nxt;
  logic [N_REQ-1:0]    w_grant;
  logic                w_gnt_vld;
  logic [PTR_W-1:0]    w_gnt_idx;
  logic [PTR_W-1:0]    w_scan_idx;
  logic [SW-1:0]       w_sum;
  logic [1:0]          w_lbl;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(N_REQ - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  function automatic logic [1:0] label_of(input logic [FLIT_W-1:0] f);
    return f[FLIT_W-1 -: 2];
  endfunction

  // Arbitration: round-robin head search when idle, owner-only forwarding when locked
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_rr_ptr;
    w_err_nxt   = 1'b0;
    w_grant     = '0;
    w_gnt_vld   = 1'b0;
    w_gnt_idx   = r_owner;
    w_scan_idx  = '0;
    w_sum       = '0;
    w_lbl       = LBL_BODY;
    case (r_state)
      S_IDLE: begin
        if (on_off_i && allocatable_i) begin
          for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_rr_ptr} + SW'(k);
            if (w_sum >= SW'(N_REQ)) w_sum = w_sum - SW'(N_REQ);
            w_scan_idx = w_sum[PTR_W-1:0];
            if (!w_gnt_vld && req_i[w_scan_idx] &&
                (label_of(req_flit_i[w_scan_idx]) == LBL_HEAD ||
                 label_of(req_flit_i[w_scan_idx]) == LBL_HEADTAIL)) begin
              w_gnt_vld = 1'b1;
              w_gnt_idx = w_scan_idx;
            end
          end
          if (w_gnt_vld) begin
            w_grant[w_gnt_idx] = 1'b1;
            w_lbl = label_of(req_flit_i[w_gnt_idx]);
            if (w_lbl == LBL_HEAD) begin
              w_state_nxt = S_LOCKED;
              w_owner_nxt = w_gnt_idx;
            end else begin
              w_ptr_nxt = wrap_inc(w_gnt_idx);
            end
          end
        end
      end
      S_LOCKED: begin
        if (req_i[r_owner]) begin
          w_lbl = label_of(req_flit_i[r_owner]);
          if (w_lbl == LBL_HEAD || w_lbl == LBL_HEADTAIL) begin
            // A new header while the owner is mid-packet is a protocol violation
            w_err_nxt = 1'b1;
          end else if (on_off_i) begin
            w_gnt_vld        = 1'b1;
            w_gnt_idx        = r_owner;
            w_grant[r_owner] = 1'b1;
            if (w_lbl == LBL_TAIL) begin
              w_state_nxt = S_IDLE;
              w_ptr_nxt   = wrap_inc(r_owner);
            end
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Arbitration state, pointer and link output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_err    <= w_err_nxt;
      r_valid  <= w_gnt_vld;
      if (w_gnt_vld) r_data <= req_flit_i[w_gnt_idx];
    end
  end

  // Grants are suppressed combinationally while reset is held
  assign grant_o = rst_n ? w_grant : '0;
  assign data_o  = r_data;
  assign valid_o = r_valid;
  assign err_o   = r_err;

endmodule

// File: tb/tb_output_link_scheduler.sv
// tb/tb_output_link_scheduler.sv - randomized and directed self-checking bench for output_link_scheduler
module tb_output_link_scheduler;

  localparam int N  = 5;
  localparam int FW = 16;
  localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, HT = 2'b11;

  logic                 clk;
  logic                 rst_n;
  logic [N-1:0]         req;
  logic [N-1:0][FW-1:0] flit;
  logic [N-1:0]         grant;
  logic [FW-1:0]        data;
  logic                 valid;
  logic                 on_off;
  logic                 alloc;
  logic                 err;

  output_link_scheduler #(.N_REQ(N), .FLIT_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req), .req_flit_i(flit), .grant_o(grant),
    .data_o(data), .valid_o(valid), .on_off_i(on_off), .allocatable_i(alloc), .err_o(err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: -1 owner means no packet in flight
  int           m_owner;
  int           m_ptr;
  logic [FW-1:0] m_data;
  logic [N-1:0] last_grant;
  logic [FW-1:0] pq [N][$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [1:0] lbl(input logic [FW-1:0] f);
    return f[FW-1 -: 2];
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 0;
    m_data  = '0;
  endfunction

  // Decide which requester the link should serve this cycle and whether the owner misbehaves
  function automatic void model_eval(output int g, output bit e);
    g = -1;
    e = 1'b0;
    if (m_owner < 0) begin
      if (on_off && alloc)
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_ptr + k) % N;
          if (g < 0 && req[i] && (lbl(flit[i]) == HEAD || lbl(flit[i]) == HT)) g = i;
        end
    end else if (req[m_owner]) begin
      if (lbl(flit[m_owner]) == HEAD || lbl(flit[m_owner]) == HT) e = 1'b1;
      else if (on_off) g = m_owner;
    end
  endfunction

  function automatic void model_update(input int g);
    if (g < 0) return;
    m_data = flit[g];
    if (m_owner < 0) begin
      if (lbl(flit[g]) == HEAD) m_owner = g;
      else m_ptr = (g + 1) % N;
    end else if (lbl(flit[g]) == TAIL) begin
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end
  endfunction

  // One clock cycle with current inputs: check grant, then the registered link outputs
  task automatic step(input string tag, output int g);
    bit e;
    logic [N-1:0] eg;
    #2;
    model_eval(g, e);
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    last_grant = grant;
    chk({tag, " grant"}, 32'(grant), 32'(eg));
    @(posedge clk);
    #1;
    model_update(g);
    chk({tag, " valid"}, 32'(valid), 32'(g >= 0));
    chk({tag, " data"}, 32'(data), 32'(m_data));
    chk({tag, " err"}, 32'(err), 32'(e));
  endtask

  task automatic set_req(input int i, input logic [1:0] l, input logic [13:0] pl);
    req[i]  = 1'b1;
    flit[i] = {l, pl};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    for (int q = 0; q < N; q++) pq[q].delete();
    #1;
    chk("rst grant", 32'(grant), 0);
    chk("rst valid", 32'(valid), 0);
    chk("rst data", 32'(data), 0);
    chk("rst err", 32'(err), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int g;
    rst_n  = 1'b0;
    req    = '0;
    flit   = '0;
    on_off = 1'b1;
    alloc  = 1'b1;
    do_reset();

    // Single HEADTAIL from requester 2; pointer then favours 3 onward
    set_req(2, HT, 14'h122);
    step("tp1", g);
    chk("tp1 onehot", 32'(last_grant), 32'(5'b00100));
    req = '0;
    set_req(0, HT, 14'h100);
    set_req(4, HT, 14'h144);
    step("tp1 ptr", g);
    chk("tp1 ptr winner", 32'(last_grant), 32'(5'b10000));

    // Two 3-flit packets back to back from 0 and 3
    do_reset();
    for (int c = 0; c < 6; c++) begin
      int p0, p3;
      p0 = (c < 3) ? c : 3;
      p3 = (c < 3) ? 0 : c - 3;
      req = '0;
      if (c < 3) set_req(0, (p0 == 0) ? HEAD : (p0 == 1) ? BODY : TAIL, 14'(16 + c));
      set_req(3, (p3 == 0) ? HEAD : (p3 == 1) ? BODY : TAIL, 14'(48 + c));
      step("tp2", g);
      chk("tp2 order", 32'(last_grant), (c < 3) ? 32'(5'b00001) : 32'(5'b01000));
    end

    // Backpressure mid-packet with a competing head
    do_reset();
    set_req(1, HEAD, 14'h11);
    step("tp3 head", g);
    set_req(1, BODY, 14'h12);
    set_req(4, HEAD, 14'h41);
    on_off = 1'b0;
    step("tp3 off0", g);
    step("tp3 off1", g);
    on_off = 1'b1;
    step("tp3 body", g);
    set_req(1, TAIL, 14'h13);
    step("tp3 tail", g);
    req[1] = 1'b0;
    step("tp3 next", g);
    chk("tp3 winner4", 32'(last_grant), 32'(5'b10000));

    // allocatable gates heads only
    do_reset();
    set_req(0, HEAD, 14'h01);
    alloc = 1'b0;
    for (int c = 0; c < 3; c++) step("tp4 wait", g);
    alloc = 1'b1;
    step("tp4 head", g);
    chk("tp4 granted", 32'(last_grant), 32'(5'b00001));
    alloc = 1'b0;
    set_req(0, BODY, 14'h02);
    step("tp4 body", g);
    set_req(0, TAIL, 14'h03);
    step("tp4 tail", g);
    alloc = 1'b1;

    // Owner re-issuing a header while locked
    do_reset();
    set_req(2, HEAD, 14'h21);
    step("tp5 head", g);
    set_req(2, HEAD, 14'h22);
    set_req(0, HEAD, 14'h01);
    step("tp5 viol", g);
    chk("tp5 err pulse", 32'(err), 1);
    set_req(2, BODY, 14'h23);
    step("tp5 body", g);
    chk("tp5 still owner", 32'(last_grant), 32'(5'b00100));
    set_req(2, TAIL, 14'h24);
    step("tp5 tail", g);

    // Asynchronous reset in the middle of a packet
    do_reset();
    set_req(3, HEAD, 14'h31);
    step("tp6 head", g);
    set_req(3, BODY, 14'h32);
    step("tp6 body", g);
    set_req(3, TAIL, 14'h33);
    #2;
    rst_n = 1'b0;
    #1;
    chk("tp6 rst grant", 32'(grant), 0);
    chk("tp6 rst valid", 32'(valid), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req = '0;
    set_req(0, HEAD, 14'h01);
    set_req(3, HEAD, 14'h34);
    step("tp6 after", g);
    chk("tp6 winner0", 32'(last_grant), 32'(5'b00001));

    // Randomized well-formed packet traffic
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pq[i].size() == 0 && $urandom_range(3) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          if (len == 1) pq[i].push_back({HT, 14'($urandom)});
          else begin
            pq[i].push_back({HEAD, 14'($urandom)});
            for (int b = 0; b < len - 2; b++) pq[i].push_back({BODY, 14'($urandom)});
            pq[i].push_back({TAIL, 14'($urandom)});
          end
        end
        req[i]  = (pq[i].size() != 0) && ($urandom_range(3) != 0);
        flit[i] = (pq[i].size() != 0) ? pq[i][0] : '0;
      end
      on_off = ($urandom_range(4) != 0);
      alloc  = ($urandom_range(4) != 0);
      step("rnd pkt", g);
      if (g >= 0) void'(pq[g].pop_front());
    end

    // Randomized arbitrary labels, including protocol violations
    do_reset();
    for (int c = 0; c < 300; c++) begin
      req = N'($urandom);
      for (int i = 0; i < N; i++) flit[i] = FW'($urandom);
      on_off = ($urandom_range(3) != 0);
      alloc  = ($urandom_range(3) != 0);
      step("rnd any", g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
